// File: rtl/lcd_read_controller.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_read_controller
//  Description : HD44780-style LCD read sequencer. A rising edge on iStart
//                runs one read cycle (SETUP -> EN_HIGH -> RECOVER). The cycle
//                can repeat as a busy-flag poll until BF clears or the poll
//                limit is reached. LCD_DATA is only ever sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_read_controller #(
  parameter int SETUP_CYC  = 2,
  parameter int EN_CYC     = 16,
  parameter int POLL_LIMIT = 1024
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPoll,
  output logic [7:0] oData,
  output logic       oBusy,
  output logic [6:0] oAddr,
  output logic       oDone,
  output logic       oTimeout,
  input  logic [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int MAX_CYC = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int POLL_W  = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  EN_LAST    = CNT_W'(EN_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_LIMIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    EN_HIGH = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [POLL_W-1:0]   poll_cnt_q,  poll_cnt_d;
  logic                pre_start_q, pre_start_d;
  logic                rs_lat_q,    rs_lat_d;
  logic                poll_lat_q,  poll_lat_d;
  logic [7:0]          data_q,      data_d;
  logic                busy_q,      busy_d;
  logic [6:0]          addr_q,      addr_d;
  logic                done_q,      done_d;
  logic                timeout_q,   timeout_d;
  logic                lcd_rw_q,    lcd_rw_d;
  logic                lcd_en_q,    lcd_en_d;
  logic                lcd_rs_q,    lcd_rs_d;

  logic                start_edge;

  assign start_edge = iStart & ~pre_start_q;

  // Next-state and next-output computation for the read sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    poll_cnt_d  = poll_cnt_q;
    pre_start_d = iStart;
    rs_lat_d    = rs_lat_q;
    poll_lat_d  = poll_lat_q;
    data_d      = data_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    lcd_rw_d    = lcd_rw_q;
    lcd_en_d    = lcd_en_q;
    lcd_rs_d    = lcd_rs_q;

    case (state_q)
      IDLE, DONE: begin
        // A new request is accepted only when no read cycle is in flight
        if (start_edge) begin
          rs_lat_d   = iRS;
          poll_lat_d = iPoll;
          done_d     = 1'b0;
          timeout_d  = 1'b0;
          poll_cnt_d = '0;
          cnt_d      = '0;
          lcd_rw_d   = 1'b1;
          lcd_rs_d   = iRS;
          lcd_en_d   = 1'b0;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d    = '0;
          lcd_en_d = 1'b1;
          state_d  = EN_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      EN_HIGH: begin
        // The bus is captured on the same edge that drops LCD_EN
        if (cnt_q == EN_LAST) begin
          cnt_d    = '0;
          lcd_en_d = 1'b0;
          data_d   = LCD_DATA;
          if (!rs_lat_q) begin
            busy_d = LCD_DATA[7];
            addr_d = LCD_DATA[6:0];
          end
          state_d = RECOVER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RECOVER: begin
        if (cnt_q == EN_LAST) begin
          cnt_d = '0;
          // busy_q holds the BF captured in this iteration's EN_HIGH
          if (poll_lat_q && !rs_lat_q && busy_q) begin
            if (poll_cnt_q == POLL_LAST) begin
              timeout_d = 1'b1;
              done_d    = 1'b1;
              lcd_rw_d  = 1'b0;
              state_d   = DONE;
            end else begin
              poll_cnt_d = poll_cnt_q + 1'b1;
              state_d    = SETUP;
            end
          end else begin
            timeout_d = 1'b0;
            done_d    = 1'b1;
            lcd_rw_d  = 1'b0;
            state_d   = DONE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        lcd_en_d = 1'b0;
        lcd_rw_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any transaction in flight
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      poll_cnt_q  <= '0;
      pre_start_q <= 1'b0;
      rs_lat_q    <= 1'b0;
      poll_lat_q  <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      lcd_rw_q    <= 1'b0;
      lcd_en_q    <= 1'b0;
      lcd_rs_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      poll_cnt_q  <= poll_cnt_d;
      pre_start_q <= pre_start_d;
      rs_lat_q    <= rs_lat_d;
      poll_lat_q  <= poll_lat_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      lcd_rw_q    <= lcd_rw_d;
      lcd_en_q    <= lcd_en_d;
      lcd_rs_q    <= lcd_rs_d;
    end
  end

  assign oData    = data_q;
  assign oBusy    = busy_q;
  assign oAddr    = addr_q;
  assign oDone    = done_q;
  assign oTimeout = timeout_q;
  assign LCD_RW   = lcd_rw_q;
  assign LCD_EN   = lcd_en_q;
  assign LCD_RS   = lcd_rs_q;

endmodule
`default_nettype wire

// File: doc/lcd_read_controller.md
LCD_READ_CONTROLLER -- requirements
Module: lcd_read_controller

Interface
REQ-001 Parameter SETUP_CYC, default 2, sets the number of cycles RW/RS are stable before LCD_EN rises.
REQ-002 Parameter EN_CYC, default 16, sets both the LCD_EN high width and the LCD_EN low recovery width, in cycles.
REQ-003 Parameter POLL_LIMIT, default 1024, sets the maximum number of status reads in one poll transaction.
REQ-004 iCLK  input  1  system clock, 50 MHz.
REQ-005 iRST_N  input  1  reset, asynchronous, active-low.
REQ-006 iStart  input  1  a rising edge requests one transaction.
REQ-007 iRS  input  1  read type: 0 = busy-flag/address, 1 = data RAM.
REQ-008 iPoll  input  1  when 1 with iRS=0, repeat status reads until BF=0.
REQ-009 oData  output  8  byte captured by the last read.
REQ-010 oBusy  output  1  BF (bit 7) from the last status read.
REQ-011 oAddr  output  7  address counter (bits 6:0) from the last status read.
REQ-012 oDone  output  1  level signal, 1 = transaction complete.
REQ-013 oTimeout  output  1  level signal, 1 = last poll ended with BF still 1.
REQ-014 LCD_DATA  input  8  LCD data bus; this block never drives it.
REQ-015 LCD_RW  output  1  1 during a transaction, 0 otherwise.
REQ-016 LCD_EN  output  1  enable strobe.
REQ-017 LCD_RS  output  1  register select, driven from the latched iRS.

Function
REQ-018 Start detection shall use a preStart register, and a rising edge is iStart=1 with preStart=0 at a clock edge.
REQ-019 The FSM states shall be IDLE, SETUP, EN_HIGH, RECOVER and DONE, and all outputs shall be registered.
REQ-020 A start edge seen in IDLE or DONE shall:
- latch iRS and iPoll;
- clear oDone and oTimeout;
- clear the poll counter;
- set LCD_RW=1 and LCD_RS=latched iRS;
- move to SETUP.
REQ-021 A start edge seen in SETUP, EN_HIGH or RECOVER shall be ignored.
REQ-022 SETUP shall last SETUP_CYC cycles with LCD_EN=0, then move to EN_HIGH with LCD_EN=1.
REQ-023 EN_HIGH shall last exactly EN_CYC cycles; LCD_DATA is sampled at the clock edge that ends EN_HIGH, and LCD_EN falls at that same edge.
REQ-024 On every sample, oData shall take LCD_DATA.
- If latched RS=0, oBusy and oAddr also take LCD_DATA[7] and LCD_DATA[6:0].
- If latched RS=1, oBusy and oAddr are unchanged.
REQ-025 RECOVER shall last EN_CYC cycles with LCD_EN=0 and LCD_RW=1.
REQ-026 At the end of RECOVER, the FSM shall go back to SETUP and increment the poll counter if all of the following hold:
- latched iPoll=1;
- latched RS=0;
- sampled BF=1;
- poll counter < POLL_LIMIT-1.
REQ-027 At the end of RECOVER, if latched iPoll=1, RS=0, BF=1 and poll counter = POLL_LIMIT-1, the FSM shall go to DONE with oTimeout=1.
REQ-028 In every other case at the end of RECOVER, the FSM shall go to DONE with oTimeout=0.
REQ-029 iPoll shall be ignored when latched RS=1, giving a single read.
REQ-030 On entry to DONE, oDone shall be 1 and LCD_RW=0, and these shall hold until the next accepted start edge.
REQ-031 With the start edge sampled at edge k, LCD_EN shall be high for edges k+SETUP_CYC+1 through k+SETUP_CYC+EN_CYC.
REQ-032 With the start edge sampled at edge k, oDone shall register 1 at edge k+SETUP_CYC+2*EN_CYC (k+34 at defaults) for a single read.
REQ-033 Each extra poll iteration shall add SETUP_CYC+2*EN_CYC cycles (34 at defaults).
REQ-034 The poll counter shall be ceil(log2(POLL_LIMIT)) bits wide and shall never wrap.

Reset
REQ-035 While iRST_N=0, independent of iCLK, the block shall hold state IDLE, with oData=0, oBusy=0, oAddr=0, oDone=0, oTimeout=0, LCD_EN=0, LCD_RW=0, LCD_RS=0, preStart=0 and poll counter=0.
REQ-036 Reset asserted mid-transaction shall drop LCD_EN and LCD_RW immediately, discard the transaction, and not assert oDone.
REQ-037 If iStart=1 at the first clock edge after reset release, that shall count as a rising edge.

Verification
REQ-038 Single status read: iRS=0, iPoll=0, LCD_DATA=8'h45, start pulse at edge k -> LCD_EN high for edges k+3..k+18, then oDone=1 at k+34 with oData=8'h45, oBusy=0, oAddr=7'h45, oTimeout=0.
REQ-039 Data read: iRS=1, LCD_DATA=8'hC1 -> LCD_RS=1 throughout, oData=8'hC1, oBusy and oAddr unchanged from their prior values.
REQ-040 Poll: iRS=0, iPoll=1, LCD_DATA=8'h80 for the first 3 samples, then 8'h12 -> 4 EN pulses, oDone at k+136, oBusy=0, oAddr=7'h12, oTimeout=0.
REQ-041 Timeout: POLL_LIMIT=4, LCD_DATA held at 8'hFF -> exactly 4 EN pulses, then oDone=1, oTimeout=1, oBusy=1.
REQ-042 Ignored start: a second iStart edge during EN_HIGH -> no restart, oDone at k+34 as usual; a new edge in DONE clears oDone on the next edge.
REQ-043 Reset mid-op: iRST_N=0 during EN_HIGH -> LCD_EN=0 and LCD_RW=0 asynchronously, all outputs zero, and oDone stays 0 after release.
